tanh4_act_arbiter: RTL and testbench

TANH4_ACT_ARBITER -- requirements
Module: tanh4_act_arbiter

---
 rtl/tanh4_act_pkg.sv | 16 +
 rtl/tanh_core4.sv | 15 +
 rtl/tanh4_act_arbiter.sv | 110 +++++++++++
 tb/tb_tanh4_act_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tanh4_act_pkg.sv
// Shared widths and pipeline-stage record for the tanh4 activation arbiter.
// Every file that shares the tanh core imports these definitions.
package tanh4_act_pkg;

    localparam int DATA_W   = 4;
    localparam int CNT_W    = 16;
    localparam int ID_MAX_W = 3;

    // The id field is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } stage_t;

endpackage

// File: rtl/tanh_core4.sv
// Stateless 4-bit approximate tanh: odd inputs map to small positive codes,
// and even inputs map to either zero or saturation.
module tanh_core4
    import tanh4_act_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    logic sat_hi;

    assign sat_hi = ~x[0] & (x[1] | (x[3] & x[2]));
    assign y      = {sat_hi, sat_hi | (x[1] & x[2]), x[0], x[0]};

endmodule

// File: rtl/tanh4_act_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one tanh core.
// Operands pass through a two-register pipeline: S1 holds the operand, and S2 holds the result.
module tanh4_act_arbiter
    import tanh4_act_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [IDW-1:0]           rsp_id,
    input  logic                     rsp_ready,
    output logic [CNT_W-1:0]         op_count
);

    stage_t              s1_q;
    stage_t              s2_q;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      scan_idx;
    logic                grant_found;
    logic                s2_load;
    logic                s1_load;
    logic                accept;
    logic [DATA_W-1:0]   grant_data;
    logic [DATA_W-1:0]   core_out;
    logic [DATA_W-1:0]   req_ops [NREQ];
    logic                unused_id_bits;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_ops[g] = req_data[g*DATA_W +: DATA_W];
    end

    // The scan begins at rr_ptr, so an idle requester at the pointer is skipped in the same cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign s2_load    = !s2_q.valid || rsp_ready;
    assign s1_load    = !s1_q.valid || s2_load;
    assign accept     = rst_n && grant_found && s1_load;
    assign req_ready  = accept ? (NREQ'(1) << grant_idx) : '0;
    assign grant_data = req_ops[grant_idx];

    tanh_core4 u_core (
        .x (s1_q.data),
        .y (core_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (s1_load) begin
            s1_q.valid <= accept;
            if (accept) begin
                s1_q.id   <= ID_MAX_W'(grant_idx);
                s1_q.data <= grant_data;
            end
        end
    end

    // S2 keeps its payload on a bubble so the result stays stable until a new result replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (s2_load) begin
            s2_q.valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_q.id   <= s1_q.id;
                s2_q.data <= core_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_q.valid && rsp_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    assign rsp_valid      = s2_q.valid;
    assign rsp_data       = s2_q.data;
    assign rsp_id         = s2_q.id[IDW-1:0];
    assign unused_id_bits = ^s2_q.id;

endmodule

// File: tb/tb_tanh4_act_arbiter.sv
// Directed bench for tanh4_act_arbiter covering reset, grant order, latency, skip, stall, flush and counter wrap.
// Expected values are hand-derived from the core equations.
module tb_tanh4_act_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic [15:0] op_count;

    int vectors;
    int miscompares;

    // Operands for requesters 3..0 are 0111, 0000, 0001 and 0010.
    logic [15:0] base_ops;
    logic [3:0]  expect_by_id [4];
    logic [3:0]  sweep_expect [16];
    logic [3:0]  exp_ready;

    tanh4_act_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data, input logic rdy);
        req_valid = valid;
        req_data  = data;
        rsp_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        base_ops     = 16'h7012;
        expect_by_id = '{4'b1100, 4'b0011, 4'b0000, 4'b0111};
        sweep_expect = '{4'h0, 4'h3, 4'hC, 4'h3, 4'h0, 4'h3, 4'hC, 4'h7,
                         4'h0, 4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC, 4'h7};

        // Reset values, with requester 0 already waiting
        rst_n = 1'b1;
        applyStimulus(4'b0000, base_ops, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        applyStimulus(4'b0001, base_ops, 1'b1);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_data",  32'(rsp_data),  32'h0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("rst_op_count",  32'(op_count),  32'h0);

        // Single request accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("single_grant", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, base_ops, 1'b1);
        checkOutput("single_lat1_valid", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("single_rsp_data",  32'(rsp_data),  32'hC);
        checkOutput("single_rsp_id",    32'(rsp_id),    32'h0);
        tick();
        checkOutput("single_op_count", 32'(op_count), 32'h1);
        checkOutput("single_drained",  32'(rsp_valid), 32'h0);

        // rr_ptr is 1 and only requester 3 is valid
        applyStimulus(4'b1000, base_ops, 1'b1);
        checkOutput("skip_grant", 32'(req_ready), 32'h8);
        tick();

        // All four requesters valid; the pointer wrapped to 0 after the skip grant
        for (int c = 0; c < 10; c++) begin
            applyStimulus((c < 8) ? 4'hF : 4'h0, base_ops, 1'b1);
            exp_ready = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            checkOutput("rr_grant", 32'(req_ready), 32'(exp_ready));
            if (c == 0) begin
                checkOutput("rr_first_empty", 32'(rsp_valid), 32'h0);
            end else if (c == 1) begin
                checkOutput("skip_rsp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("skip_rsp_id",    32'(rsp_id),    32'h3);
                checkOutput("skip_rsp_data",  32'(rsp_data),  32'h7);
            end else begin
                checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("rr_rsp_id",    32'(rsp_id),    32'((c - 2) % 4));
                checkOutput("rr_rsp_data",  32'(rsp_data),  32'(expect_by_id[(c - 2) % 4]));
            end
            tick();
        end
        checkOutput("rr_drained", 32'(rsp_valid), 32'h0);

        // Sweep all 16 operands through requester 0 at one per cycle
        for (int i = 0; i < 18; i++) begin
            applyStimulus((i < 16) ? 4'b0001 : 4'b0000, {base_ops[15:4], 4'(i)}, 1'b1);
            checkOutput("sweep_grant", 32'(req_ready), (i < 16) ? 32'h1 : 32'h0);
            if (i >= 2) begin
                checkOutput("sweep_rsp_data", 32'(rsp_data), 32'(sweep_expect[i - 2]));
                checkOutput("sweep_rsp_id",   32'(rsp_id),   32'h0);
            end
            tick();
        end

        // Backpressure: requester 1 result stalls while requester 2 waits in S1
        applyStimulus(4'b0010, base_ops, 1'b1);
        checkOutput("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(4'b0100, base_ops, 1'b0);
        checkOutput("bp_grant2", 32'(req_ready), 32'h4);
        tick();
        for (int s = 0; s < 5; s++) begin
            applyStimulus(4'b0001, base_ops, 1'b0);
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp_hold_data",  32'(rsp_data),  32'h3);
            checkOutput("bp_hold_id",    32'(rsp_id),    32'h1);
            checkOutput("bp_full_ready", 32'(req_ready), 32'h0);
            tick();
        end
        applyStimulus(4'b0000, base_ops, 1'b1);
        checkOutput("bp_release_id", 32'(rsp_id), 32'h1);
        tick();
        checkOutput("bp_next_valid", 32'(rsp_valid), 32'h1);
        checkOutput("bp_next_data",  32'(rsp_data),  32'h0);
        checkOutput("bp_next_id",    32'(rsp_id),    32'h2);
        tick();
        checkOutput("bp_drained",  32'(rsp_valid), 32'h0);
        checkOutput("count_total", 32'(op_count),  32'd28);

        // Reset pulse with two operands in flight
        applyStimulus(4'b0001, base_ops, 1'b1);
        tick();
        applyStimulus(4'b0001, base_ops, 1'b1);
        tick();
        applyStimulus(4'b0000, base_ops, 1'b0);
        checkOutput("mid_inflight", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        applyStimulus(4'b0001, base_ops, 1'b1);
        checkOutput("mid_rst_valid",    32'(rsp_valid), 32'h0);
        checkOutput("mid_rst_count",    32'(op_count),  32'h0);
        checkOutput("mid_rst_req_rdy",  32'(req_ready), 32'h0);
        applyStimulus(4'b0000, base_ops, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            checkOutput("mid_no_output", 32'(rsp_valid), 32'h0);
        end
        checkOutput("mid_count_after", 32'(op_count), 32'h0);

        // op_count wraps after 65536 deliveries
        applyStimulus(4'b0001, base_ops, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        applyStimulus(4'b0000, base_ops, 1'b1);
        repeat (3) tick();
        checkOutput("wrap_max", 32'(op_count), 32'hFFFF);
        applyStimulus(4'b0001, base_ops, 1'b1);
        tick();
        applyStimulus(4'b0000, base_ops, 1'b1);
        repeat (3) tick();
        checkOutput("wrap_zero", 32'(op_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
